// File: rtl/mix_columns_serial.sv
// AES MixColumns stage with valid/ready handshakes on both sides.
// Each CALC cycle transforms COLS_PER_CYCLE columns using shared column mixers.
// A per-block bypass passes the state through unchanged for the final round.
// Optional macro INV_MIX_COLUMNS_EN adds i_inverse to select InvMixColumns.
module mix_columns_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [0:127] i_data,
    input  logic         i_bypass,
`ifdef INV_MIX_COLUMNS_EN
    input  logic         i_inverse,
`endif
    output logic         o_valid,
    input  logic         i_ready,
    output logic [0:127] o_data
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         NCYC     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] CNT_LAST = 2'(NCYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   r_cnt;
    logic [0:127] r_in;
    logic [0:127] r_data;
`ifdef INV_MIX_COLUMNS_EN
    logic         r_inv;
`endif

    logic [1:0]   w_col_idx [COLS_PER_CYCLE];
    logic [31:0]  w_col_in  [COLS_PER_CYCLE];
    logic [31:0]  w_col_res [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 of the column sits in the most significant byte.
    function automatic logic [31:0] fwd_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, t0, t1, t2, t3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        t0 = xtime(a0);
        t1 = xtime(a1);
        t2 = xtime(a2);
        t3 = xtime(a3);
        return {t0 ^ t1 ^ a1 ^ a2 ^ a3,
                a0 ^ t1 ^ t2 ^ a2 ^ a3,
                a0 ^ a1 ^ t2 ^ t3 ^ a3,
                t0 ^ a0 ^ a1 ^ a2 ^ t3};
    endfunction

`ifdef INV_MIX_COLUMNS_EN
    // k is a constant coefficient; its set bits pick terms of the xtime chain.
    function automatic logic [7:0] mul_k(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mul_k(a0, 4'he) ^ mul_k(a1, 4'hb) ^ mul_k(a2, 4'hd) ^ mul_k(a3, 4'h9),
                mul_k(a0, 4'h9) ^ mul_k(a1, 4'he) ^ mul_k(a2, 4'hb) ^ mul_k(a3, 4'hd),
                mul_k(a0, 4'hd) ^ mul_k(a1, 4'h9) ^ mul_k(a2, 4'he) ^ mul_k(a3, 4'hb),
                mul_k(a0, 4'hb) ^ mul_k(a1, 4'hd) ^ mul_k(a2, 4'h9) ^ mul_k(a3, 4'he)};
    endfunction
`endif

    // One mixer per lane; the counter selects which columns the lanes see.
    genvar g;
    generate
        for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
            assign w_col_idx[g] = 2'(int'(r_cnt) * COLS_PER_CYCLE + g);
            assign w_col_in[g]  = r_in[32*w_col_idx[g] +: 32];
`ifdef INV_MIX_COLUMNS_EN
            assign w_col_res[g] = r_inv ? inv_mix(w_col_in[g]) : fwd_mix(w_col_in[g]);
`else
            assign w_col_res[g] = fwd_mix(w_col_in[g]);
`endif
        end
    endgenerate

    assign o_ready = (r_state == ST_IDLE);
    assign o_valid = (r_state == ST_OUT);
    assign o_data  = r_data;

    // Control FSM, input capture and column-by-column result update.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_in    <= '0;
            r_data  <= '0;
`ifdef INV_MIX_COLUMNS_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_in <= i_data;
`ifdef INV_MIX_COLUMNS_EN
                        r_inv <= i_inverse;
`endif
                        if (i_bypass) begin
                            r_data  <= i_data;
                            r_state <= ST_OUT;
                        end else begin
                            r_cnt   <= 2'd0;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                        r_data[32*w_col_idx[j] +: 32] <= w_col_res[j];
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= 2'd0;
                        r_state <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
